memory_access: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline. Sits between the execute stage and write_back, and drives the write_back inputs.
- Performs loads and stores against the data memory through a req/ack handshake, and stalls the pipeline while an access is outstanding.
- Aligns and sign- or zero-extends load data.
- Registers ALU result, load data, destination register and mem_to_reg into the MEM/WB pipeline register.

---
 rtl/memory_access_pkg.sv | 44 ++++
 rtl/memory_access_load_align.sv | 36 +++
 rtl/memory_access.sv | 204 ++++++++++++++++++++
 tb/tb_memory_access.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_pkg: shared types and helpers for the RV32I MEM stage.            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} mem_state_t;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} mem_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Any funct3 not naming a byte or halfword access is a word access.
  function automatic mem_size_t access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (access_size(funct3))
      SZ_B:    return 1'b1;
      SZ_H:    return ~addr_lo[0];
      default: return (addr_lo == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (access_size(funct3))
      SZ_B:    return 4'b0001 << addr_lo;
      SZ_H:    return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_access_load_align.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | load_align: selects the addressed byte/halfword and extends it.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_unsigned;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    is_unsigned = (funct3 == F3_BU) || (funct3 == F3_HU);
    case (access_size(funct3))
      SZ_B:    result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_H:    result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memory_access.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | memory_access: RV32I MEM stage with req/ack data memory and timeout.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module memory_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_from_ex,
  input  logic [31:0] alu_result_from_ex,
  input  logic [31:0] write_data_from_ex,
  input  logic [4:0]  immed_11_7_from_ex,
  input  logic        mem_read_control,
  input  logic        mem_write_control,
  input  logic        mem_to_reg_from_ex,
  input  logic [2:0]  funct3_from_ex,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        stall_mem,
  output logic [31:0] read_data_from_memory,
  output logic [31:0] alu_result_from_memory,
  output logic        mem_to_reg_control,
  output logic [4:0]  immed_11_7_from_memory,
  output logic        misaligned_err,
  output logic        bus_error
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  mem_state_t      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  // Context of the outstanding access, captured in the request cycle.
  logic [31:0]     addr_q, addr_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            is_load_q, is_load_d;
  logic [4:0]      rd_q, rd_d;
  logic            m2r_q, m2r_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     alu_q, alu_d;
  logic            wb_m2r_q, wb_m2r_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            mis_q, mis_d;
  logic            berr_q, berr_d;

  logic            stall;
  logic            leave;
  logic            is_mem_op;
  logic [31:0]     store_lanes;
  logic [31:0]     load_data;

  load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .result  (load_data)
  );

  always_comb begin
    is_mem_op = mem_read_control | mem_write_control;
    case (access_size(funct3_from_ex))
      SZ_B:    store_lanes = {4{write_data_from_ex[7:0]}};
      SZ_H:    store_lanes = {2{write_data_from_ex[15:0]}};
      default: store_lanes = write_data_from_ex;
    endcase

    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    is_load_d = is_load_q;
    rd_d      = rd_q;
    m2r_d     = m2r_q;
    req_d     = req_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = '0;
    alu_d     = '0;
    wb_m2r_d  = 1'b0;
    wb_rd_d   = '0;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    stall     = 1'b0;
    leave     = 1'b0;

    if (state_q == IDLE) begin
      if (valid_from_ex) begin
        if (!is_mem_op) begin
          alu_d    = alu_result_from_ex;
          wb_m2r_d = mem_to_reg_from_ex;
          wb_rd_d  = immed_11_7_from_ex;
        end else if (!is_aligned(funct3_from_ex, alu_result_from_ex[1:0])) begin
          mis_d = 1'b1;
        end else begin
          stall     = 1'b1;
          state_d   = ACCESS;
          cnt_d     = '0;
          addr_d    = alu_result_from_ex;
          funct3_d  = funct3_from_ex;
          is_load_d = mem_read_control;
          rd_d      = immed_11_7_from_ex;
          m2r_d     = mem_to_reg_from_ex;
          req_d     = 1'b1;
          we_d      = ~mem_read_control;
          be_d      = byte_enable(funct3_from_ex, alu_result_from_ex[1:0]);
          wdata_d   = mem_read_control ? 32'd0 : store_lanes;
        end
      end
    end else begin
      // Ack takes priority over a timeout landing in the same cycle.
      if (dmem_ack) begin
        alu_d    = addr_q;
        wb_m2r_d = m2r_q;
        wb_rd_d  = rd_q;
        rdata_d  = is_load_q ? load_data : 32'd0;
        leave    = 1'b1;
      end else if (cnt_q == TO_LAST) begin
        berr_d = 1'b1;
        leave  = 1'b1;
      end else begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (leave) begin
      state_d = IDLE;
      addr_d  = '0;
      req_d   = 1'b0;
      we_d    = 1'b0;
      be_d    = '0;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      funct3_q  <= '0;
      is_load_q <= 1'b0;
      rd_q      <= '0;
      m2r_q     <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      alu_q     <= '0;
      wb_m2r_q  <= 1'b0;
      wb_rd_q   <= '0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      funct3_q  <= funct3_d;
      is_load_q <= is_load_d;
      rd_q      <= rd_d;
      m2r_q     <= m2r_d;
      req_q     <= req_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      alu_q     <= alu_d;
      wb_m2r_q  <= wb_m2r_d;
      wb_rd_q   <= wb_rd_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
    end
  end

  assign dmem_req               = req_q;
  assign dmem_we                = we_q;
  assign dmem_addr              = {addr_q[31:2], 2'b00};
  assign dmem_wdata             = wdata_q;
  assign dmem_be                = be_q;
  assign stall_mem              = stall & ~rst;
  assign read_data_from_memory  = rdata_q;
  assign alu_result_from_memory = alu_q;
  assign mem_to_reg_control     = wb_m2r_q;
  assign immed_11_7_from_memory = wb_rd_q;
  assign misaligned_err         = mis_q;
  assign bus_error              = berr_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
// Directed and randomized checks of memory_access against a transaction-level model.
module tb_memory_access;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_from_ex;
  logic [31:0] alu_result_from_ex;
  logic [31:0] write_data_from_ex;
  logic [4:0]  immed_11_7_from_ex;
  logic        mem_read_control;
  logic        mem_write_control;
  logic        mem_to_reg_from_ex;
  logic [2:0]  funct3_from_ex;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        stall_mem;
  logic [31:0] read_data_from_memory;
  logic [31:0] alu_result_from_memory;
  logic        mem_to_reg_control;
  logic [4:0]  immed_11_7_from_memory;
  logic        misaligned_err;
  logic        bus_error;

  int checks = 0;
  int failures = 0;

  memory_access #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(7)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .valid_from_ex          (valid_from_ex),
    .alu_result_from_ex     (alu_result_from_ex),
    .write_data_from_ex     (write_data_from_ex),
    .immed_11_7_from_ex     (immed_11_7_from_ex),
    .mem_read_control       (mem_read_control),
    .mem_write_control      (mem_write_control),
    .mem_to_reg_from_ex     (mem_to_reg_from_ex),
    .funct3_from_ex         (funct3_from_ex),
    .dmem_rdata             (dmem_rdata),
    .dmem_ack               (dmem_ack),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .dmem_addr              (dmem_addr),
    .dmem_wdata             (dmem_wdata),
    .dmem_be                (dmem_be),
    .stall_mem              (stall_mem),
    .read_data_from_memory  (read_data_from_memory),
    .alu_result_from_memory (alu_result_from_memory),
    .mem_to_reg_control     (mem_to_reg_control),
    .immed_11_7_from_memory (immed_11_7_from_memory),
    .misaligned_err         (misaligned_err),
    .bus_error              (bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes for a funct3 code.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
    longint v;
    int     sz;
    sz = size_of(f3);
    if (sz == 4) return word;
    v = longint'(word >> (8 * (addr % 4)));
    v = v % (longint'(1) << (8 * sz));
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  task automatic drive_idle();
    valid_from_ex      = 1'b0;
    mem_read_control   = 1'b0;
    mem_write_control  = 1'b0;
    mem_to_reg_from_ex = 1'b0;
    dmem_ack           = 1'b0;
  endtask

  task automatic check_wb(input string tag, input logic [31:0] alu, input logic [4:0] rd,
                          input logic m2r, input logic [31:0] rdata, input logic mis,
                          input logic berr);
    check({tag, "_alu"}, alu_result_from_memory, alu);
    check({tag, "_rd"}, 32'(immed_11_7_from_memory), 32'(rd));
    check({tag, "_m2r"}, 32'(mem_to_reg_control), 32'(m2r));
    check({tag, "_rdata"}, read_data_from_memory, rdata);
    check({tag, "_mis"}, 32'(misaligned_err), 32'(mis));
    check({tag, "_berr"}, 32'(bus_error), 32'(berr));
  endtask

  // One instruction through MEM; ack_delay = ACCESS cycles without ack (-1: never).
  task automatic run_op(input string tag, input bit v, input bit rdc, input bit wrc, input bit m2r,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] word, input logic [4:0] rd, input int ack_delay,
                        output int stalls);
    int          sz;
    bit          is_mem;
    bit          mis;
    bit          ack;
    bit          done;
    logic [31:0] e_be;
    logic [31:0] e_wd;
    stalls = 0;
    sz     = size_of(f3);
    is_mem = v && (rdc || wrc);
    mis    = is_mem && ((addr % sz) != 0);
    e_be   = ((32'd1 << sz) - 32'd1) << (addr % 4);
    e_wd   = (sz == 1) ? wd[7:0] * 32'h0101_0101 : (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;

    valid_from_ex      = v;
    mem_read_control   = rdc;
    mem_write_control  = wrc;
    mem_to_reg_from_ex = m2r;
    funct3_from_ex     = f3;
    alu_result_from_ex = addr;
    write_data_from_ex = wd;
    immed_11_7_from_ex = rd;
    dmem_ack           = 1'($urandom_range(0, 1));
    dmem_rdata         = $urandom;
    @(negedge clk);
    check({tag, "_stall_req"}, 32'(stall_mem), 32'(is_mem && !mis));
    check({tag, "_req_idle"}, 32'(dmem_req), 32'd0);
    if (stall_mem) stalls++;

    if (!is_mem || mis) begin
      @(posedge clk); #1;
      drive_idle();
      check_wb(tag, (v && !is_mem) ? addr : 32'd0, (v && !is_mem) ? rd : 5'd0,
               v && !is_mem && m2r, 32'd0, mis, 1'b0);
      if (mis) begin
        @(posedge clk); #1;
        check({tag, "_mis_pulse"}, 32'(misaligned_err), 32'd0);
        check({tag, "_mis_noreq"}, 32'(dmem_req), 32'd0);
      end
    end else begin
      @(posedge clk); #1;
      for (int w = 0; w < TIMEOUT; w++) begin
        ack        = (w == ack_delay);
        done       = ack || (w == TIMEOUT - 1);
        dmem_ack   = ack;
        dmem_rdata = ack ? word : $urandom;
        @(negedge clk);
        check({tag, "_req"}, 32'(dmem_req), 32'd1);
        check({tag, "_addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
        check({tag, "_we"}, 32'(dmem_we), 32'(!rdc));
        if (!rdc) begin
          check({tag, "_be"}, 32'(dmem_be), e_be);
          check({tag, "_wdata"}, dmem_wdata, e_wd);
        end
        check({tag, "_stall"}, 32'(stall_mem), 32'(!done));
        if (stall_mem) stalls++;
        @(posedge clk); #1;
        if (done) begin
          drive_idle();
          if (ack)
            check_wb({tag, "_done"}, addr, rd, m2r, rdc ? load_model(word, addr, f3) : 32'd0,
                     1'b0, 1'b0);
          else
            check_wb({tag, "_tmo"}, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b1);
          break;
        end
      end
      @(posedge clk); #1;
      check({tag, "_berr_pulse"}, 32'(bus_error), 32'd0);
      check({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
    end
  endtask

  initial begin
    int          stalls;
    bit          rdc;
    bit          wrc;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  f3_list [8];
    f3_list = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    rst                = 1'b1;
    funct3_from_ex     = 3'b000;
    alu_result_from_ex = 32'd0;
    write_data_from_ex = 32'd0;
    immed_11_7_from_ex = 5'd0;
    dmem_rdata         = 32'd0;
    drive_idle();
    #12;
    check_wb("reset", 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("reset_req", 32'(dmem_req), 32'd0);
    check("reset_stall", 32'(stall_mem), 32'd0);
    check("reset_be", 32'(dmem_be), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("alu", 1, 0, 0, 1, 3'b000, 32'h0000_1234, 32'd0, 32'd0, 5'd5, 0, stalls);
    check("alu_stalls", 32'(stalls), 32'd0);

    run_op("lb", 1, 1, 0, 0, 3'b000, 32'h103, 32'd0, 32'h80AB_CDEF, 5'd9, 3, stalls);
    check("lb_stalls", 32'(stalls), 32'd4);
    run_op("lbu", 1, 1, 0, 0, 3'b100, 32'h103, 32'd0, 32'h80AB_CDEF, 5'd9, 3, stalls);

    run_op("sh", 1, 0, 1, 0, 3'b001, 32'h202, 32'hDEAD_BEEF, 32'd0, 5'd0, 2, stalls);
    run_op("lw_mis", 1, 1, 0, 0, 3'b010, 32'h101, 32'd0, 32'd0, 5'd4, 0, stalls);
    check("lw_mis_stalls", 32'(stalls), 32'd0);

    run_op("lw_tmo", 1, 1, 0, 0, 3'b010, 32'h300, 32'd0, 32'd0, 5'd6, -1, stalls);
    check("lw_tmo_stalls", 32'(stalls), 32'd64);
    run_op("lw_late", 1, 1, 0, 0, 3'b010, 32'h304, 32'd0, 32'h1357_9BDF, 5'd6, TIMEOUT - 1, stalls);

    // Reset arriving while an access is outstanding.
    valid_from_ex      = 1'b1;
    mem_read_control   = 1'b1;
    mem_write_control  = 1'b0;
    funct3_from_ex     = 3'b010;
    alu_result_from_ex = 32'h400;
    immed_11_7_from_ex = 5'd7;
    dmem_ack           = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_req_before", 32'(dmem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req", 32'(dmem_req), 32'd0);
    check("rst_mid_stall", 32'(stall_mem), 32'd0);
    check_wb("rst_mid", 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("sw_after_rst", 1, 0, 1, 0, 3'b010, 32'h500, 32'hCAFE_F00D, 32'd0, 5'd0, 1, stalls);

    for (int i = 0; i < 40; i++) begin
      rdc  = 1'($urandom_range(0, 1));
      wrc  = 1'($urandom_range(0, 1));
      f3   = f3_list[$urandom_range(0, 7)];
      addr = $urandom;
      if ($urandom_range(0, 2) == 0) addr[1:0] = 2'b00;
      run_op("rand", 1'($urandom_range(0, 5) != 0), rdc, wrc, 1'($urandom_range(0, 1)), f3, addr,
             $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 4)), stalls);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
